// File: rtl/cpu_run_ctrl_if.sv
//==============================================================================
// Module   : cpu_run_ctrl_if
// Brief    : Debug-host command port (valid/ready) for the CPU run controller.
// Revision : 1.0
//==============================================================================
`default_nettype none

interface cpu_run_ctrl_if;
    logic        cmdValid;
    logic        cmdReady;
    logic [2:0]  cmdCode;
    logic [11:0] cmdArg;

    modport master (
        output cmdValid,
        output cmdCode,
        output cmdArg,
        input  cmdReady
    );

    modport slave (
        input  cmdValid,
        input  cmdCode,
        input  cmdArg,
        output cmdReady
    );
endinterface

`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
//==============================================================================
// Module   : cpu_run_ctrl
// Brief    : Run/halt/step sequencer driving the 4-bit core clock-enable, with
//            one PC breakpoint and a retired-instruction counter.
// Revision : 1.0
//==============================================================================
`default_nettype none

module cpu_run_ctrl #(
    parameter bit RESET_RUN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rstN,
    cpu_run_ctrl_if.slave         cmd,
    input  wire logic [2:0]       cycle,
    input  wire logic             needImm,
    input  wire logic             immFetchActive,
    input  wire logic [11:0]      pcAddr,
    output logic                  cpuEn,
    output logic                  halted,
    output logic [1:0]            haltCause,
    output logic                  bpHit,
    output logic                  stepDone,
    output logic [CNT_W-1:0]      instrCount
);

    localparam logic [2:0] c_ST_HALT     = 3'd0;
    localparam logic [2:0] c_ST_RUN      = 3'd1;
    localparam logic [2:0] c_ST_DRAIN    = 3'd2;
    localparam logic [2:0] c_ST_STEP_CYC = 3'd3;
    localparam logic [2:0] c_ST_STEP_INS = 3'd4;

    localparam logic [2:0] c_CMD_RUN      = 3'd1;
    localparam logic [2:0] c_CMD_HALT     = 3'd2;
    localparam logic [2:0] c_CMD_STEP_CYC = 3'd3;
    localparam logic [2:0] c_CMD_STEP_INS = 3'd4;
    localparam logic [2:0] c_CMD_SET_BP   = 3'd5;
    localparam logic [2:0] c_CMD_CLR_BP   = 3'd6;
    localparam logic [2:0] c_CMD_CLR_CNT  = 3'd7;

    localparam logic [1:0] c_CAUSE_RESET = 2'd0;
    localparam logic [1:0] c_CAUSE_CMD   = 2'd1;
    localparam logic [1:0] c_CAUSE_BP    = 2'd2;
    localparam logic [1:0] c_CAUSE_STEP  = 2'd3;

    localparam logic [2:0] c_ST_RESET = RESET_RUN ? c_ST_RUN : c_ST_HALT;

    logic [2:0]       state_q,       state_d;
    logic             bp_en_q,       bp_en_d;
    logic [11:0]      bp_addr_q,     bp_addr_d;
    logic             bp_skip_q,     bp_skip_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [1:0]       halt_cause_q,  halt_cause_d;
    logic             bp_hit_q,      bp_hit_d;
    logic             step_done_q,   step_done_d;

    logic w_cmd_ready;
    logic w_accept;
    logic w_bp_match;
    logic w_cpu_en;
    logic w_bnd;

    assign w_cmd_ready = (state_q == c_ST_HALT) || (state_q == c_ST_RUN);
    assign w_accept    = cmd.cmdValid && w_cmd_ready;

    // Checked at A1 before the instruction starts, so a hit stops it from issuing.
    assign w_bp_match  = bp_en_q && (cycle == 3'd0) && (pcAddr == bp_addr_q) && !bp_skip_q;

    assign w_cpu_en    = ((state_q == c_ST_RUN) && !w_bp_match) ||
                         (state_q == c_ST_DRAIN) ||
                         (state_q == c_ST_STEP_CYC) ||
                         (state_q == c_ST_STEP_INS);

    // A 2-word instruction only retires at the X3 of its immediate word.
    assign w_bnd       = w_cpu_en && (cycle == 3'd7) && (immFetchActive || !needImm);

    always_comb begin
        state_d       = state_q;
        bp_en_d       = bp_en_q;
        bp_addr_d     = bp_addr_q;
        bp_skip_d     = bp_skip_q;
        instr_count_d = instr_count_q;
        halt_cause_d  = halt_cause_q;
        bp_hit_d      = 1'b0;
        step_done_d   = 1'b0;

        if (w_cpu_en) begin
            bp_skip_d = 1'b0;
        end
        if (w_bnd) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end

        if (w_accept) begin
            case (cmd.cmdCode)
                c_CMD_SET_BP: begin
                    bp_addr_d = cmd.cmdArg;
                    bp_en_d   = 1'b1;
                end
                c_CMD_CLR_BP:  bp_en_d       = 1'b0;
                c_CMD_CLR_CNT: instr_count_d = '0;
                default: ;
            endcase
        end

        case (state_q)
            c_ST_HALT: begin
                if (w_accept) begin
                    case (cmd.cmdCode)
                        c_CMD_RUN: begin
                            state_d   = c_ST_RUN;
                            bp_skip_d = 1'b1;
                        end
                        c_CMD_STEP_CYC: begin
                            state_d   = c_ST_STEP_CYC;
                            bp_skip_d = 1'b1;
                        end
                        c_CMD_STEP_INS: begin
                            state_d   = c_ST_STEP_INS;
                            bp_skip_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            c_ST_RUN: begin
                if (w_bp_match) begin
                    state_d      = c_ST_HALT;
                    halt_cause_d = c_CAUSE_BP;
                    bp_hit_d     = 1'b1;
                end else if (w_accept && (cmd.cmdCode == c_CMD_HALT)) begin
                    // A HALT landing on a boundary edge needs no drain phase.
                    if (w_bnd) begin
                        state_d      = c_ST_HALT;
                        halt_cause_d = c_CAUSE_CMD;
                    end else begin
                        state_d = c_ST_DRAIN;
                    end
                end
            end
            c_ST_DRAIN: begin
                if (w_bnd) begin
                    state_d      = c_ST_HALT;
                    halt_cause_d = c_CAUSE_CMD;
                end
            end
            c_ST_STEP_CYC: begin
                state_d      = c_ST_HALT;
                halt_cause_d = c_CAUSE_STEP;
                step_done_d  = 1'b1;
            end
            c_ST_STEP_INS: begin
                if (w_bnd) begin
                    state_d      = c_ST_HALT;
                    halt_cause_d = c_CAUSE_STEP;
                    step_done_d  = 1'b1;
                end
            end
            default: state_d = c_ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q       <= c_ST_RESET;
            bp_en_q       <= 1'b0;
            bp_addr_q     <= 12'h000;
            bp_skip_q     <= 1'b0;
            instr_count_q <= '0;
            halt_cause_q  <= c_CAUSE_RESET;
            bp_hit_q      <= 1'b0;
            step_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bp_en_q       <= bp_en_d;
            bp_addr_q     <= bp_addr_d;
            bp_skip_q     <= bp_skip_d;
            instr_count_q <= instr_count_d;
            halt_cause_q  <= halt_cause_d;
            bp_hit_q      <= bp_hit_d;
            step_done_q   <= step_done_d;
        end
    end

    assign cmd.cmdReady = w_cmd_ready;
    assign cpuEn        = w_cpu_en;
    assign halted       = (state_q == c_ST_HALT);
    assign haltCause    = halt_cause_q;
    assign bpHit        = bp_hit_q;
    assign stepDone     = step_done_q;
    assign instrCount   = instr_count_q;

endmodule

`default_nettype wire
